// File: rtl/rv_muldiv_pkg.sv
// rtl/rv_muldiv_pkg.sv - shared MDU funct3 encodings and controller states
package rv_muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    function automatic logic f3_is_div(input logic [2:0] f);
        return f[2];
    endfunction

endpackage

// File: rtl/rv_muldiv_negate.sv
// rtl/rv_muldiv_negate.sv - combinational conditional two's-complement negator
module rv_muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + 1'b1) : value;

endmodule

// File: rtl/rv_muldiv_unit.sv
// rtl/rv_muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle
module rv_muldiv_unit
    import rv_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_t       state;
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic             sign_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;

    logic             a_signed, b_signed, neg_a, neg_b;
    logic             is_div_in, is_rem_in, b_zero, div_ovf, special_in, sign_in;
    logic [WIDTH-1:0] abs_a, abs_b, special_result;

    assign in_ready = (state == ST_IDLE) && !flush;
    assign busy     = (state != ST_IDLE);

    assign a_signed  = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU)
                    || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign b_signed  = (funct3 == F3_MUL) || (funct3 == F3_MULH)
                    || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign neg_a     = a_signed & a[WIDTH-1];
    assign neg_b     = b_signed & b[WIDTH-1];
    assign is_div_in = f3_is_div(funct3);
    assign is_rem_in = funct3[2] & funct3[1];
    assign b_zero    = (b == '0);
    assign div_ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM))
                    && (a == MSB_ONLY) && (b == ALL_ONES);
    assign special_in = is_div_in & (b_zero | div_ovf);
    // Remainder takes the dividend's sign; quotient and product take the XOR.
    assign sign_in   = is_rem_in ? neg_a : (neg_a ^ neg_b);

    always_comb begin
        special_result = '0;
        if (b_zero)
            special_result = is_rem_in ? a : ALL_ONES;
        else if (!is_rem_in)
            special_result = a;
    end

    rv_muldiv_negate #(.W(WIDTH)) u_abs_a (.value(a), .negate(neg_a), .result(abs_a));
    rv_muldiv_negate #(.W(WIDTH)) u_abs_b (.value(b), .negate(neg_b), .result(abs_b));

    // Iteration datapath: hi/lo are the product halves, or remainder/quotient.
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    logic [2*WIDTH-1:0] fix_src, fix_res;
    logic [WIDTH-1:0]   fix_sel;

    assign fix_src = op_q[2] ? {{WIDTH{1'b0}}, (op_q[1] ? hi_q : lo_q)} : {hi_q, lo_q};
    assign fix_sel = ((op_q == F3_MUL) || op_q[2]) ? fix_res[WIDTH-1:0]
                                                   : fix_res[2*WIDTH-1:WIDTH];

    rv_muldiv_negate #(.W(2*WIDTH)) u_fix_neg (.value(fix_src), .negate(sign_q), .result(fix_res));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            tag_q       <= '0;
            sign_q      <= 1'b0;
            cnt         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            out_valid   <= 1'b0;
            result      <= '0;
            tag_out     <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q        <= funct3;
                        tag_q       <= tag_in;
                        sign_q      <= sign_in;
                        cnt         <= '0;
                        hi_q        <= '0;
                        lo_q        <= is_div_in ? abs_a : abs_b;
                        opnd_q      <= is_div_in ? abs_b : abs_a;
                        div_by_zero <= is_div_in & b_zero;
                        if (special_in) begin
                            result    <= special_result;
                            tag_out   <= tag_in;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (op_q[2]) begin
                        hi_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        hi_q <= mul_sum[WIDTH:1];
                        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    result    <= fix_sel;
                    tag_out   <= tag_q;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb/tb_rv_muldiv_unit.sv - randomized self-checking bench for rv_muldiv_unit
module tb_rv_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [4:0]  tag_in = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  tag_out;
    logic        div_by_zero;
    logic        busy;

    int total = 0;
    int bad = 0;

    rv_muldiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
        .a(a), .b(b), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .tag_out(tag_out),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (f)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = ux / uy; return p[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                p = ux % uy; return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && y == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // lat counts edges from the accept edge (as 1) to the edge that raises out_valid.
    task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] t, output logic [31:0] r, output logic [4:0] rt,
                         output logic rdz, output int lat);
        @(negedge clk);
        in_valid = 1'b1; funct3 = f; a = x; b = y; tag_in = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result; rt = tag_out; rdz = div_by_zero;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        total++; if (tag_out !== 5'd0) begin bad++; $display("FAIL reset_tag got=%h exp=0", tag_out); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_by_zero); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] e;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[13];
        logic [31:0] r; logic [4:0] rt; logic rdz; int lat;
        v = '{
            '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34},
            '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 34},
            '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34},
            '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 34},
            '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 34},
            '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 34},
            '{3'd5, 32'd100,        32'd7,         32'd14,        1'b0, 34},
            '{3'd7, 32'd100,        32'd7,         32'd2,         1'b0, 34},
            '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         1'b0, 34},
            '{3'd4, 32'd9,          32'd0,         32'hFFFF_FFFF, 1'b1, 1},
            '{3'd7, 32'd5,          32'd0,         32'd5,         1'b1, 1},
            '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1},
            '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 1}
        };
        for (int i = 0; i < 13; i++) begin
            do_op(v[i].f, v[i].x, v[i].y, 5'(i + 5), r, rt, rdz, lat);
            total++; if (r !== v[i].e) begin bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, v[i].e); end
            total++; if (rt !== 5'(i + 5)) begin bad++; $display("FAIL dir%0d_tag got=%h exp=%h", i, rt, 5'(i + 5)); end
            total++; if (rdz !== v[i].dz) begin bad++; $display("FAIL dir%0d_dz got=%b exp=%b", i, rdz, v[i].dz); end
            total++; if (lat != v[i].lat) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, r, e; logic [4:0] t, rt; logic [2:0] f; logic rdz; int lat, el;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7)); x = pick(); y = pick(); t = 5'($urandom);
            e = model(f, x, y); el = model_latency(f, x, y);
            do_op(f, x, y, t, r, rt, rdz, lat);
            total++; if (r !== e) begin bad++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h got=%h exp=%h", i, f, x, y, r, e); end
            total++; if (rt !== t) begin bad++; $display("FAIL rnd%0d_tag got=%h exp=%h", i, rt, t); end
            total++; if (rdz !== (f[2] && y == 0)) begin bad++; $display("FAIL rnd%0d_dz got=%b exp=%b", i, rdz, (f[2] && y == 0)); end
            total++; if (lat != el) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, el); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e, r; logic [4:0] rt; logic rdz; int lat;
        e = model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd3; a = 32'h1234_5678; b = 32'h9ABC_DEF0; tag_in = 5'd9;
        @(posedge clk); #1; in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; funct3 = 3'd5; a = 32'd50; b = 32'd0; tag_in = 5'd3;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp%0d_in_ready got=%b exp=0", i, in_ready); end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_out_valid got=%b exp=1", i, out_valid); end
            total++; if (result !== e) begin bad++; $display("FAIL bp%0d_result got=%h exp=%h", i, result, e); end
            total++; if (tag_out !== 5'd9) begin bad++; $display("FAIL bp%0d_tag got=%h exp=9", i, tag_out); end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL bp_release_idle got=%b%b exp=10", in_ready, busy); end
        do_op(3'd0, 32'd6, 32'd7, 5'd17, r, rt, rdz, lat);
        total++; if (r !== 32'd42 || rt !== 5'd17) begin bad++; $display("FAIL b2b_result got=%h/%h exp=0000002a/11", r, rt); end
        total++; if (lat != 34) begin bad++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd0; a = 32'd11; b = 32'd13; tag_in = 5'd4;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'd5; a = 32'd100; b = 32'd0; tag_in = 5'd8;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_idle busy=%b ov=%b exp=00", busy, out_valid); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid || busy) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_no_output got=%0d exp=0", seen); end
        // flush while a result is waiting in DONE
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd4; a = 32'd9; b = 32'd0; tag_in = 5'd21;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_done got=%b%b exp=00", out_valid, busy); end
    endtask

    task automatic test_async_reset();
        logic [31:0] r; logic [4:0] rt; logic rdz; int lat;
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd1; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF; tag_in = 5'd30;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); #2; rst_n = 1'b0; #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL arst_ctrl got=%b%b exp=00", out_valid, busy); end
        total++; if (result !== 32'd0 || tag_out !== 5'd0 || div_by_zero !== 1'b0) begin bad++; $display("FAIL arst_data got=%h/%h/%b exp=0", result, tag_out, div_by_zero); end
        @(negedge clk); rst_n = 1'b1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
        do_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd2, r, rt, rdz, lat);
        total++; if (r !== model(3'd6, 32'hFFFF_FF9C, 32'd7)) begin bad++; $display("FAIL arst_after_op got=%h exp=%h", r, model(3'd6, 32'hFFFF_FF9C, 32'd7)); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
